// File: rtl/taxel_pkg.sv
// rtl/taxel_pkg.sv - shared types and constants for the taxel packetizer
package taxel_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        IDX,
        DHI,
        DLO
    } ser_state_e;

    typedef struct packed {
        logic [3:0]  sw;
        logic [3:0]  rd;
        logic [15:0] data;
    } taxel_entry_t;

endpackage

// File: rtl/taxel_fifo.sv
// rtl/taxel_fifo.sv - synchronous sample FIFO; a push into a full FIFO is taken when a pop frees a slot that cycle
module taxel_fifo
    import taxel_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = taxel_entry_t
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   push_i,
    input  T                       push_data_i,
    input  logic                   pop_i,
    output T                       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           push_ok;
    logic           pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/taxel_packetizer.sv
// rtl/taxel_packetizer.sv - tags ADC samples with the taxel address, buffers them and emits 4-byte packets
module taxel_packetizer
    import taxel_pkg::*;
#(
    parameter int SW_WIRE_CNT = 16,
    parameter int RD_WIRE_CNT = 16,
    parameter int ADC_W       = 12,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic                         sample_valid,
    input  logic [ADC_W-1:0]             sample_data,
    input  logic [$clog2(SW_WIRE_CNT):0] sw_mux_sel,
    input  logic [$clog2(RD_WIRE_CNT):0] rd_mux_sel,
    output logic                         scan_enable,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         frame_done,
    output logic                         overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ser_state_e   state_q, state_d;
    taxel_entry_t hold_q, hold_d;
    logic         frame_done_q, frame_done_d;
    logic         overflow_q, overflow_d;
    logic         scan_enable_q, scan_enable_d;

    taxel_entry_t push_entry;
    taxel_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic         pop;
    logic         last_taxel;

    logic [7:0]   sw_ext;
    logic [7:0]   rd_ext;
    logic         unused_sel_bits;

    assign sw_ext          = 8'(sw_mux_sel);
    assign rd_ext          = 8'(rd_mux_sel);
    assign unused_sel_bits = ^{sw_ext[7:4], rd_ext[7:4]};

    assign push_entry.sw   = sw_ext[3:0];
    assign push_entry.rd   = rd_ext[3:0];
    assign push_entry.data = 16'(sample_data);

    taxel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (taxel_entry_t)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst         (rst),
        .push_i      (sample_valid),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign last_taxel = (hold_q.sw == 4'(SW_WIRE_CNT - 1)) &&
                        (hold_q.rd == 4'(RD_WIRE_CNT - 1));

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        pop          = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = head;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) state_d = IDX;
            end
            IDX: begin
                tx_valid = 1'b1;
                tx_data  = {hold_q.sw, hold_q.rd};
                if (tx_ready) state_d = DHI;
            end
            DHI: begin
                tx_valid = 1'b1;
                tx_data  = hold_q.data[15:8];
                if (tx_ready) state_d = DLO;
            end
            DLO: begin
                tx_valid = 1'b1;
                tx_data  = hold_q.data[7:0];
                if (tx_ready) begin
                    frame_done_d = last_taxel;
                    // Chain straight into the next packet so there is no idle byte slot.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        hold_d  = head;
                        state_d = SYNC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign overflow_d    = overflow_q | (sample_valid && fifo_full && !pop);
    assign scan_enable_d = (fifo_count < CNT_W'(FIFO_DEPTH - 2));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            scan_enable_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            scan_enable_q <= scan_enable_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
    assign scan_enable = scan_enable_q;

endmodule

// File: tb/tb_taxel_packetizer.sv
// tb/tb_taxel_packetizer.sv - directed self-checking bench for taxel_packetizer
module tb_taxel_packetizer;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic [4:0]  sw_mux_sel;
    logic [4:0]  rd_mux_sel;
    logic        scan_enable;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        frame_done;
    logic        overflow;

    always #5 clk_in = ~clk_in;

    taxel_packetizer dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sw_mux_sel   (sw_mux_sel),
        .rd_mux_sel   (rd_mux_sel),
        .scan_enable  (scan_enable),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rxq[$];
    logic [7:0] exq[$];
    int         frame_cnt = 0;
    int         frame_pos = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    typedef struct {
        logic [3:0]  sw;
        logic [3:0]  rd;
        logic [11:0] d;
        logic [31:0] bytes;
        logic        fd;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void add_pkt(input logic [3:0] sw, input logic [3:0] rd, input logic [11:0] d);
        exq.push_back(8'hA5);
        exq.push_back({sw, rd});
        exq.push_back({4'h0, d[11:8]});
        exq.push_back(d[7:0]);
    endfunction

    task automatic check_stream(input string name);
        int bad = 0;
        chk({name, "_len"}, 32'(rxq.size()), 32'(exq.size()));
        for (int i = 0; i < rxq.size() && i < exq.size(); i++) begin
            if (rxq[i] !== exq[i]) bad++;
        end
        chk({name, "_bytes_bad"}, 32'(bad), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_sample(input logic [3:0] sw, input logic [3:0] rd, input logic [11:0] d);
        sample_valid = 1'b1;
        sw_mux_sel   = {1'b0, sw};
        rd_mux_sel   = {1'b0, rd};
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    // Byte monitor: logs handshakes and enforces hold-while-stalled.
    always @(negedge clk_in) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(tx_valid), 32'd1);
                chk("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (frame_done) begin
                frame_cnt++;
                frame_pos = rxq.size();
            end
            if (tx_valid && tx_ready) rxq.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    initial begin
        logic [3:0]  s_sw;
        logic [3:0]  s_rd;
        logic [11:0] s_d;

        vt[0] = '{sw: 4'd3,  rd: 4'd5,  d: 12'hABC, bytes: 32'hA5350ABC, fd: 1'b0};
        vt[1] = '{sw: 4'd0,  rd: 4'd0,  d: 12'h000, bytes: 32'hA5000000, fd: 1'b0};
        vt[2] = '{sw: 4'd15, rd: 4'd14, d: 12'hFFF, bytes: 32'hA5FE0FFF, fd: 1'b0};
        vt[3] = '{sw: 4'd15, rd: 4'd15, d: 12'h801, bytes: 32'hA5FF0801, fd: 1'b1};
        vt[4] = '{sw: 4'd14, rd: 4'd15, d: 12'h07E, bytes: 32'hA5EF007E, fd: 1'b0};

        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        sw_mux_sel   = '0;
        rd_mux_sel   = '0;
        tx_ready     = 1'b0;
        repeat (3) tick();
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_scan_enable", 32'(scan_enable), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        chk("scan_en_at_release", 32'(scan_enable), 32'd0);
        tick();
        chk("scan_en_rise", 32'(scan_enable), 32'd1);

        // Single packets with tx_ready held high, cycle-exact.
        tx_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            chk("vec_idle_valid", 32'(tx_valid), 32'd0);
            drive_sample(vt[v].sw, vt[v].rd, vt[v].d);
            chk("vec_n1_valid", 32'(tx_valid), 32'd0);
            tick();
            for (int k = 0; k < 4; k++) begin
                chk("vec_valid", 32'(tx_valid), 32'd1);
                chk("vec_byte", 32'(tx_data), 32'(vt[v].bytes[31-8*k -: 8]));
                tick();
            end
            chk("vec_frame_done", 32'(frame_done), 32'(vt[v].fd));
            tick();
        end

        // Toggling tx_ready: bytes hold while stalled, sequence unchanged.
        rxq.delete(); exq.delete();
        add_pkt(4'd9, 4'd2, 12'h5A5);
        drive_sample(4'd9, 4'd2, 12'h5A5);
        for (int c = 0; c < 14; c++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        tx_ready = 1'b1;
        repeat (3) tick();
        check_stream("toggle");

        // Full 16x16 frame.
        rxq.delete(); exq.delete();
        frame_cnt = 0;
        for (int s = 0; s < 16; s++) begin
            for (int r = 0; r < 16; r++) begin
                s_d = 12'(s * 181 + r * 13);
                add_pkt(4'(s), 4'(r), s_d);
                drive_sample(4'(s), 4'(r), s_d);
                repeat (3) tick();
            end
        end
        repeat (10) tick();
        check_stream("scan");
        chk("scan_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("scan_frame_pos", 32'(frame_pos), 32'd1024);
        chk("scan_overflow", 32'(overflow), 32'd0);

        // Stalled output with 20 samples: one in the holding register, 16 buffered, 3 dropped.
        rxq.delete(); exq.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_sw = 4'(i);
            s_rd = ~4'(i);
            s_d  = 12'(i * 37 + 1);
            if (i < 17) add_pkt(s_sw, s_rd, s_d);
            drive_sample(s_sw, s_rd, s_d);
            chk("fill_scan_enable", 32'(scan_enable), (i <= 14) ? 32'd1 : 32'd0);
            chk("fill_overflow", 32'(overflow), (i >= 17) ? 32'd1 : 32'd0);
        end
        tx_ready = 1'b1;
        repeat (17 * 4 + 10) tick();
        check_stream("ovf_drain");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_scan_enable_back", 32'(scan_enable), 32'd1);

        // Push during the pop that frees a slot of a full FIFO.
        rst = 1'b1;
        tick();
        chk("rst_clears_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();
        rxq.delete(); exq.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            add_pkt(4'(i), 4'(i + 3), 12'(i * 99));
            drive_sample(4'(i), 4'(i + 3), 12'(i * 99));
        end
        chk("full_overflow", 32'(overflow), 32'd0);
        chk("full_scan_enable", 32'(scan_enable), 32'd0);
        tx_ready = 1'b1;
        repeat (3) tick();
        add_pkt(4'd12, 4'd1, 12'h3C7);
        drive_sample(4'd12, 4'd1, 12'h3C7);
        tx_ready = 1'b0;
        chk("samecyc_overflow", 32'(overflow), 32'd0);
        drive_sample(4'd2, 4'd2, 12'h222);
        chk("samecyc_still_full", 32'(overflow), 32'd1);
        tx_ready = 1'b1;
        repeat (17 * 4 + 10) tick();
        check_stream("samecyc");

        // Reset in the middle of the DHI byte.
        rxq.delete(); exq.delete();
        drive_sample(4'd4, 4'd6, 12'h9C3);
        repeat (3) tick();
        chk("dhi_byte", 32'(tx_data), 32'h09);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(tx_valid), 32'd0);
        chk("async_rst_data", 32'(tx_data), 32'd0);
        chk("async_rst_scan_enable", 32'(scan_enable), 32'd0);
        chk("async_rst_overflow", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        chk("post_rst_scan_low", 32'(scan_enable), 32'd0);
        tick();
        chk("post_rst_scan_high", 32'(scan_enable), 32'd1);
        rxq.delete(); exq.delete();
        add_pkt(4'd1, 4'd2, 12'h0F0);
        drive_sample(4'd1, 4'd2, 12'h0F0);
        repeat (8) tick();
        check_stream("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
